qarma128_tk_sched: RTL and testbench
====================================

# qarma128_tk_sched

Sequential tweakey scheduler for the QARMA-128 forward rounds. It sits directly upstream of the per-round combinational round instances and supplies each round's 128-bit `tk` input, one round per accepted transfer. It latches a key word and a tweak on `start`, then emits `tk_i = k0 ^ T_i ^ c_i` for i = 0..ROUNDS-1. The tweak advances through the QARMA-128 update (cell permutation h, then the cell LFSR omega) after every accepted round.

## Interface
- `ROUNDS`, 8: number of forward rounds scheduled; legal range 1..16.
- `RC`, `round_const` from `global_params.sv`: packed array of ROUNDS 128-bit constants; `RC[0]` is 0.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: load request; accepted only in IDLE.
- `k0` input 128: round key word, sampled on accepted `start`.
- `tweak` input 128: initial tweak T_0, sampled on accepted `start`.
- `tk_valid` output 1: `tk` and `round_idx` are valid.
- `tk_ready` input 1: downstream round stage accepts the current `tk`.
- `tk` output 128: round tweakey, fed to the round `tk` port.
- `round_idx` output 4: index i of the presented `tk`.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse after the last round is accepted.

## Operation
- Cell numbering: 16 cells of 8 bits; cell 0 = bits [127:120], cell 15 = bits [7:0].
- h: output cell j = input cell H[j], with H = {6,5,14,15,0,1,2,3,7,12,13,4,8,9,10,11}.
- omega: applied after h, only to cells {0,1,3,4,8,11,13}; each affected byte b becomes {b[0]^b[2], b[7:1]}. All other cells pass unchanged.
- Registers: `k_reg`, `t_reg`, `idx` (4 b), `state`.
- `tk` is combinational from registers: `k_reg ^ t_reg ^ RC[idx]`. It is the registered result of the previous update, never a function of `tk_ready`.
- FSM:
  - IDLE: `tk_valid`=0, `busy`=0. When `start`=1: load `k_reg`=k0, `t_reg`=tweak, `idx`=0; go to RUN.
  - RUN: `tk_valid`=1. On `tk_valid & tk_ready`:
    - If `idx` < ROUNDS-1: `t_reg` = omega(h(t_reg)), `idx`+1.
    - If `idx` = ROUNDS-1: go to IDLE, pulse `done` in the next cycle, clear `idx`.
    - Without `tk_ready`, all registers hold.
- `start` in RUN is ignored; no restart and no reload.
- `start` in the IDLE cycle that follows the `done` pulse is accepted normally.
- Width rules:
  - `idx` never exceeds ROUNDS-1.
  - Bit-exact XOR only; no carries.
  - `round_idx` is `idx`, zero-extended to 4 bits.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE. `tk_valid`, `busy`, `done`, `round_idx` all 0. `k_reg`, `t_reg` = 0, so `tk` = 0.
- `start` accepted at edge n: `tk_valid`=1 with round 0 from cycle n+1.
- Throughput: one round per cycle while `tk_ready`=1. A full schedule takes ROUNDS cycles from the first `tk_valid` cycle to the last acceptance.
- `done` asserts in the cycle after the final handshake. `busy` falls in that same cycle.
- Valid/ready rules:
  - `tk_valid` never drops without a handshake.
  - `tk` and `round_idx` stay stable while `tk_valid & !tk_ready`.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0, and no `done` pulse.
- ROUNDS=1: one handshake, then `done`; no tweak update occurs.

## Test plan
- Zero inputs: k0=0, tweak=0, `start`, `tk_ready`=1 held → `tk` = RC[0..7] on 8 consecutive cycles, `round_idx` 0..7, then `done` one cycle later and `busy`=0.
- Tweak update: k0=0, tweak with cell 0 = 0x01 and all other cells 0 → round 0 `tk` = 0x01 in cell 0 only. Round 1 `tk` = RC[1] ^ (0x80 in cell 4, all other cells 0).
- Key pass-through: k0=128'hFF..FF, tweak=0 → every `tk_i` = ~RC[i].
- Backpressure: drop `tk_ready` for 3 cycles at round 2 → `tk` and `round_idx`=2 held stable for all 3 cycles, `tk_valid` stays 1. Round 3 appears one cycle after `tk_ready` returns.
- `start` during RUN, with different k0/tweak, at round 4 → ignored; the remaining rounds match the original k0/tweak.
- Reset mid-operation: `rst_n`=0 during round 5 → same-cycle `tk_valid`=0 and `tk`=0, no `done` pulse. A later `start` runs a full schedule from round 0.

Source files
------------

// File: rtl/qarma128_tk_sched.sv
// qarma128_tk_sched: sequential QARMA-128 forward-round tweakey scheduler.
// Latches k0/tweak on start, then presents tk_i = k0 ^ T_i ^ RC[i] for i = 0..ROUNDS-1,
// one round per tk_valid/tk_ready handshake, advancing T through h then omega.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, k0, tweak    load request (IDLE only), key word, initial tweak
//   tk_valid, tk_ready  round tweakey handshake
//   tk, round_idx       current round tweakey and its index
//   busy, done          high while running; one-cycle pulse after the last round
module qarma128_tk_sched #(
    parameter int ROUNDS = 8,
    parameter logic [ROUNDS-1:0][127:0] RC = {
        128'hBA7C9045F12C7F9924A19947B3916CF7,
        128'h2FFD72DBD01ADFB7B8E1AFED6A267E96,
        128'h9216D5D98979FB1BD1310BA698DFB5AC,
        128'hC0AC29B7C97C50DD3F84D5B5B5470917,
        128'h452821E638D01377BE5466CF34E90C6C,
        128'hA4093822299F31D0082EFA98EC4E6C89,
        128'h243F6A8885A308D313198A2E03707344,
        128'h00000000000000000000000000000000
    }
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] k0,
    input  logic [127:0] tweak,
    output logic         tk_valid,
    input  logic         tk_ready,
    output logic [127:0] tk,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam int H [16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
    // bit j set: omega applies to cell j (cells 0,1,3,4,8,11,13)
    localparam logic [15:0] OM = 16'h291B;
    state_t state, state_nx;
    logic [127:0] k_reg, t_reg, t_nx;
    logic [3:0] idx;
    logic hs, last;
    // constants padded to 16 entries so the 4-bit index always selects in range
    logic [15:0][127:0] rc_tab;
    for (genvar i = 0; i < 16; i++) begin : g_rc
        if (i < ROUNDS) begin : g_on
            assign rc_tab[i] = RC[i];
        end else begin : g_off
            assign rc_tab[i] = '0;
        end
    end
    assign hs = tk_valid && tk_ready;
    assign last = idx == 4'(ROUNDS - 1);
    always_comb begin
        t_nx = '0;
        for (int j = 0; j < 16; j++) begin
            logic [7:0] hc;
            hc = t_reg[127-8*H[j] -: 8];
            t_nx[127-8*j -: 8] = OM[j] ? {hc[0] ^ hc[2], hc[7:1]} : hc;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) : ((hs && last) ? IDLE : RUN);
    end
    always_comb begin
        tk_valid = state == RUN;
        busy = state == RUN;
        tk = k_reg ^ t_reg ^ rc_tab[idx];
        round_idx = idx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg <= '0;
            t_reg <= '0;
            idx <= '0;
            done <= 1'b0;
        end else begin
            done <= hs && last;
            if (state == IDLE && start) begin
                k_reg <= k0;
                t_reg <= tweak;
                idx <= '0;
            end else if (hs) begin
                idx <= last ? '0 : idx + 4'd1;
                if (!last) t_reg <= t_nx;
            end
        end
    end
endmodule

// File: tb/tb_qarma128_tk_sched.sv
// tb_qarma128_tk_sched: directed self-checking bench for qarma128_tk_sched.
module tb_qarma128_tk_sched;
    localparam logic [7:0][127:0] RCT = {
        128'hBA7C9045F12C7F9924A19947B3916CF7,
        128'h2FFD72DBD01ADFB7B8E1AFED6A267E96,
        128'h9216D5D98979FB1BD1310BA698DFB5AC,
        128'hC0AC29B7C97C50DD3F84D5B5B5470917,
        128'h452821E638D01377BE5466CF34E90C6C,
        128'hA4093822299F31D0082EFA98EC4E6C89,
        128'h243F6A8885A308D313198A2E03707344,
        128'h00000000000000000000000000000000
    };
    localparam logic [127:0] K1 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] T1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] K2 = 128'h5A5A5A5AA5A5A5A5C3C3C3C33C3C3C3C;
    localparam logic [127:0] T2 = 128'hDEADBEEF0BADF00DCAFEBABE12345678;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic tk_ready = 1'b0;
    logic [127:0] k0 = '0;
    logic [127:0] tweak = '0;
    logic tk_valid, busy, done;
    logic [127:0] tk;
    logic [3:0] round_idx;
    int total = 0;
    int passed = 0;
    always #5 clk = ~clk;
    qarma128_tk_sched #(.ROUNDS(8), .RC(RCT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k0(k0), .tweak(tweak),
        .tk_valid(tk_valid), .tk_ready(tk_ready), .tk(tk), .round_idx(round_idx),
        .busy(busy), .done(done)
    );
    // reference tweak update: gather cells through the h table, then omega on the listed cells
    function automatic logic [127:0] upd(input logic [127:0] t);
        int hp [16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
        logic [7:0] c [16];
        logic [7:0] o;
        logic [127:0] r = '0;
        for (int j = 0; j < 16; j++) c[j] = t[127-8*j -: 8];
        for (int j = 0; j < 16; j++) begin
            o = c[hp[j]];
            if (j inside {0, 1, 3, 4, 8, 11, 13}) o = {o[0] ^ o[2], o[7:1]};
            r = (r << 8) | {120'b0, o};
        end
        return r;
    endfunction
    function automatic logic [127:0] tw(input logic [127:0] t0, input int n);
        logic [127:0] t = t0;
        for (int j = 0; j < n; j++) t = upd(t);
        return t;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic chk_round(input logic [127:0] k, input logic [127:0] t0, input int i);
        chk($sformatf("tk_r%0d", i), tk, k ^ tw(t0, i) ^ RCT[3'(i)]);
        chk($sformatf("idx_r%0d", i), {124'b0, round_idx}, 128'(i));
        chk($sformatf("valid_r%0d", i), {127'b0, tk_valid}, 128'd1);
    endtask
    task automatic run(input logic [127:0] k, input logic [127:0] t0, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            chk_round(k, t0, i);
            step();
        end
    endtask
    task automatic chk_done();
        chk("done_pulse", {127'b0, done}, 128'd1);
        chk("busy_after", {127'b0, busy}, 128'd0);
        chk("valid_after", {127'b0, tk_valid}, 128'd0);
    endtask
    initial begin
        tk_ready = 1'b1;
        step();
        chk("rst_valid", {127'b0, tk_valid}, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_done", {127'b0, done}, 128'd0);
        chk("rst_idx", {124'b0, round_idx}, 128'd0);
        chk("rst_tk", tk, 128'd0);
        rst_n = 1'b1;
        step();
        // zero key and tweak: tk walks the constant table
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("zero_tk_r%0d", i), tk, RCT[3'(i)]);
            chk($sformatf("zero_idx_r%0d", i), {124'b0, round_idx}, 128'(i));
            step();
        end
        chk_done();
        // start in the done cycle is accepted; single-cell tweak shows h + omega
        tweak = 128'h01000000000000000000000000000000;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("done_clear", {127'b0, done}, 128'd0);
        chk("cell0_r0", tk, 128'h01000000000000000000000000000000);
        step();
        chk("cell4_r1", tk, RCT[1] ^ 128'h00000000800000000000000000000000);
        run(128'd0, tweak, 1, 7);
        chk_done();
        step();
        // all-ones key passes through as inverted constants
        k0 = '1;
        tweak = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("key_tk_r%0d", i), tk, ~RCT[3'(i)]);
            step();
        end
        chk_done();
        step();
        // backpressure at round 2, then an ignored start at round 4
        k0 = K1;
        tweak = T1;
        start = 1'b1;
        step();
        start = 1'b0;
        run(K1, T1, 0, 1);
        tk_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_round(K1, T1, 2);
        end
        tk_ready = 1'b1;
        step();
        chk_round(K1, T1, 3);
        step();
        chk_round(K1, T1, 4);
        k0 = K2;
        tweak = T2;
        start = 1'b1;
        step();
        start = 1'b0;
        run(K1, T1, 5, 7);
        chk_done();
        step();
        // reset in the middle of round 5
        start = 1'b1;
        step();
        start = 1'b0;
        run(K2, T2, 0, 4);
        chk_round(K2, T2, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {127'b0, tk_valid}, 128'd0);
        chk("mid_rst_tk", tk, 128'd0);
        chk("mid_rst_idx", {124'b0, round_idx}, 128'd0);
        step();
        chk("mid_rst_done", {127'b0, done}, 128'd0);
        chk("mid_rst_busy", {127'b0, busy}, 128'd0);
        rst_n = 1'b1;
        step();
        chk("no_done_after_rst", {127'b0, done}, 128'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        run(K2, T2, 0, 7);
        chk_done();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
